uart_tx_ctrl: RTL and testbench

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

---
 rtl/uart_tx_ctrl.sv | 152 +++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit frame controller driving an external TX bit mux
//
// Sequences one 8N1 (or 8P1) frame per accepted request and drives the select
// of an external line mux rather than the line itself.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit period (2..65535)
//   ODD_PARITY    0 = even parity, 1 = odd parity
//
// Build option:
//   UART_TX_PARITY_EN  when defined, a parity bit is sent between the data
//                      bits and the stop bit; when undefined, no parity bit
//                      is sent and parity_bit is held at 0.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   tx_start    send request, honoured only while idle
//   tx_data     payload, captured when tx_start is accepted
//   select      TX mux select: 00 start, 01 data, 10 parity, 11 stop/idle
//   data_bit    payload bit currently on the mux data input (1 outside DATA)
//   parity_bit  parity of the captured payload
//   tx_busy     high from acceptance through the last stop-bit cycle
//   tx_done     one-cycle pulse in the final cycle of the stop bit

module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit ODD_PARITY   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic [1:0] select,
  output logic       data_bit,
  output logic       parity_bit,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic             par_q;

  logic bit_end;
  logic accept;

  assign bit_end = (state_q != S_IDLE) && (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign accept  = (state_q == S_IDLE) && tx_start;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (tx_start) state_d = S_START;
      S_START:  if (bit_end)  state_d = S_DATA;
      S_DATA: begin
        if (bit_end && (idx_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (bit_end)  state_d = S_STOP;
`endif
      S_STOP:   if (bit_end)  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Baud counter, bit index, payload shift register and parity latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else begin
      // Counter restarts on every state change so each state lasts exactly
      // one bit period; within DATA it wraps on the strobe instead.
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (state_q != S_IDLE) begin
        cnt_q <= bit_end ? '0 : cnt_q + CNT_W'(1);
      end

      if (accept) begin
        shift_q <= tx_data;
        idx_q   <= 3'd0;
        par_q   <= PAR_EN & ((^tx_data) ^ ODD_PARITY);
      end else if ((state_q == S_DATA) && bit_end) begin
        shift_q <= {1'b0, shift_q[7:1]};
        idx_q   <= idx_q + 3'd1;
      end
    end
  end

  // Outputs decode directly from registered state so reset reaches them
  // without waiting for a clock edge.
  always_comb begin
    select   = 2'b11;
    data_bit = 1'b1;
    case (state_q)
      S_START:  select = 2'b00;
      S_DATA: begin
        select   = 2'b01;
        data_bit = shift_q[0];
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: select = 2'b10;
`endif
      default:  select = 2'b11;
    endcase
  end

  assign parity_bit = par_q;
  assign tx_busy    = (state_q != S_IDLE);
  assign tx_done    = (state_q == S_STOP) && bit_end;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - self-checking bench for uart_tx_ctrl
module tb_uart_tx_ctrl;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FL = PAR ? 11 * CPB : 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;

  logic [1:0] sel0, sel1;
  logic       db0, db1, pb0, pb1, busy0, busy1, done0, done1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .ODD_PARITY(1'b0)) dut_even (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
    .select(sel0), .data_bit(db0), .parity_bit(pb0),
    .tx_busy(busy0), .tx_done(done0)
  );

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .ODD_PARITY(1'b1)) dut_odd (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
    .select(sel1), .data_bit(db1), .parity_bit(pb1),
    .tx_busy(busy1), .tx_done(done1)
  );

  typedef struct {
    logic [7:0] d;
    bit         pe;
    bit         po;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] exp_sel(input int k);
    int p;
    p = k / CPB;
    if (p == 0) return 2'b00;
    if (p <= 8) return 2'b01;
    if (PAR && p == 9) return 2'b10;
    return 2'b11;
  endfunction

  // Sends one frame and checks it cycle by cycle; returns at the first idle sample.
  task automatic run_frame(input logic [7:0] d, input bit pe, input bit po,
                           input int inject_k, input bit hold, input string tag);
    int sel_bad, db_bad, pb_bad, twin_bad, done_at, done_cnt, busy_len, p;
    sel_bad = -1; db_bad = -1; pb_bad = -1; twin_bad = -1;
    done_at = -1; done_cnt = 0; busy_len = 0;
    tx_data  = d;
    tx_start = 1'b1;
    step();
    if (!hold) tx_start = 1'b0;
    for (int k = 0; k < FL + 8; k++) begin
      if (!busy0) break;
      busy_len++;
      p = k / CPB;
      if (sel0 !== exp_sel(k) && sel_bad < 0) sel_bad = k;
      if (p >= 1 && p <= 8 && (db0 !== d[p-1] || db1 !== d[p-1]) && db_bad < 0) db_bad = k;
      if ((pb0 !== (PAR ? pe : 1'b0) || pb1 !== (PAR ? po : 1'b0)) && pb_bad < 0) pb_bad = k;
      if ((sel1 !== sel0 || busy1 !== busy0 || done1 !== done0) && twin_bad < 0) twin_bad = k;
      if (done0) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (k == inject_k) begin
        tx_data  = 8'hFF;
        tx_start = 1'b1;
      end else if (!hold) begin
        tx_start = 1'b0;
      end
      step();
    end
    check({tag, " busy_len"}, busy_len, FL);
    check({tag, " done_cycle"}, done_at, FL - 1);
    check({tag, " done_count"}, done_cnt, 1);
    check({tag, " select_first_bad_cycle"}, sel_bad, -1);
    check({tag, " data_bit_first_bad_cycle"}, db_bad, -1);
    check({tag, " parity_first_bad_cycle"}, pb_bad, -1);
    check({tag, " odd_dut_first_bad_cycle"}, twin_bad, -1);
    check({tag, " idle_select"}, sel0, 2'b11);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_seen;
    vecs[0] = '{8'hA5, 1'b0, 1'b1};
    vecs[1] = '{8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 1'b1};
    vecs[3] = '{8'h07, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b1};
    vecs[5] = '{8'h80, 1'b1, 1'b0};

    // Reset state, sampled between edges with rst high
    #12;
    check("rst select", sel0, 2'b11);
    check("rst busy", busy0, 1'b0);
    check("rst done", done0, 1'b0);
    check("rst data_bit", db0, 1'b1);
    check("rst parity_even", pb0, 1'b0);
    check("rst parity_odd", pb1, 1'b0);
    rst = 1'b0;

    // Table-driven frames; first one also exercises acceptance on the first edge after reset
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].d, vecs[i].pe, vecs[i].po, -1, 1'b0, $sformatf("vec%0d", i));
    end

    // tx_start with 0xFF during DATA must be ignored
    run_frame(8'h3C, 1'b0, 1'b1, 10, 1'b0, "ignore_start");
    tx_start  = 1'b0;
    busy_seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (busy0 || busy1) busy_seen++;
      step();
    end
    check("ignore_start no_second_frame", busy_seen, 0);

    // Reset during DATA index 3 aborts the frame immediately
    tx_data  = 8'h81;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    for (int k = 0; k < 17; k++) step();
    check("pre_abort select", sel0, 2'b01);
    #2;
    rst = 1'b1;
    #1;
    check("abort select", sel0, 2'b11);
    check("abort busy", busy0, 1'b0);
    check("abort done", done0, 1'b0);
    check("abort data_bit", db0, 1'b1);
    step();
    check("abort held select", sel0, 2'b11);
    check("abort held done", done0, 1'b0);
    #2;
    rst = 1'b0;
    run_frame(8'h81, 1'b0, 1'b1, -1, 1'b0, "after_abort");

    // Back-to-back with tx_start held: exactly one idle cycle between frames
    run_frame(8'h55, 1'b0, 1'b1, -1, 1'b1, "b2b_first");
    check("b2b gap busy", busy0, 1'b0);
    check("b2b gap done", done0, 1'b0);
    run_frame(8'hAA, 1'b0, 1'b1, -1, 1'b1, "b2b_second");
    tx_start = 1'b0;
    step();
    check("b2b end busy", busy0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
